// File: rtl/apb_xbar_pkg.sv
// Shared types, default sizes and the round-robin pick function used by the
// apb_xbar_rr crossbar.
package apb_xbar_pkg;

  localparam int NUM_MASTERS_DEF = 4;
  localparam int NUM_SLAVES_DEF  = 4;
  localparam int NUM_BRDCST_DEF  = 2;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int ADDR_WIDTH_DEF  = 6;
  localparam int FIFO_DEPTH_DEF  = 4;

  localparam int MID_W = $clog2(NUM_MASTERS_DEF);
  localparam int CNT_W = $clog2(FIFO_DEPTH_DEF + 1);
  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  // The pick function handles up to RR_MAX requesters.
  localparam int RR_MAX   = 32;
  localparam int RR_IDX_W = 5;

  typedef enum logic [1:0] {
    UNICAST = 2'd0,
    BRDCST  = 2'd1,
    INVALID = 2'd2
  } addr_class_e;

  typedef struct packed {
    logic                hit;
    logic [RR_IDX_W-1:0] idx;
  } rr_res_t;

  // First set request at or after ptr, wrapping modulo n.
  function automatic rr_res_t rr_pick(input logic [RR_MAX-1:0] req,
                                      input int unsigned       ptr,
                                      input int unsigned       n);
    rr_res_t     res;
    int unsigned j;
    res = '0;
    j   = 0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      if (i < n) begin
        j = ptr + i;
        if (j >= n) j = j - n;
        if (!res.hit && req[j]) begin
          res.hit = 1'b1;
          res.idx = RR_IDX_W'(j);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_xbar_rr_if.sv
// Bus bundle of the crossbar: master-side request channels, broadcast
// subscriptions and slave-side output channels.
interface apb_xbar_rr_if #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 4,
  parameter int NUM_BRDCST  = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int MID_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
);
  logic [NUM_MASTERS-1:0]            m_valid;
  logic [NUM_MASTERS-1:0]            m_ready;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_BRDCST*NUM_SLAVES-1:0]  brdcst_sub;
  logic [NUM_SLAVES-1:0]             s_valid;
  logic [NUM_SLAVES-1:0]             s_ready;
  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_data;
  logic [NUM_SLAVES*MID_W-1:0]       s_src;

  // slave: the crossbar's view; master: the surrounding producers/consumers.
  modport slave (input  m_valid, m_data, m_addr, brdcst_sub, s_ready,
                 output m_ready, s_valid, s_data, s_src);
  modport master (output m_valid, m_data, m_addr, brdcst_sub, s_ready,
                  input  m_ready, s_valid, s_data, s_src);
endinterface

// File: rtl/apb_xbar_fifo.sv
// Per-slave output FIFO holding payload plus source ID, first-word-fall-through.
// The head is forced to zero while empty so no stale entry is ever exposed.
module apb_xbar_fifo #(
  parameter int DW    = 32,
  parameter int SW    = 2,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic [SW-1:0] push_src_i,
  input  logic          ready_i,
  output logic          full_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [SW-1:0] src_o
);
  logic [DW+SW-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_s, pop_s;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign push_s  = push_i & ~full_o;
  assign pop_s   = valid_o & ready_i;
  assign {data_o, src_o} = valid_o ? mem_q[rd_q] : '0;

  // next pointers and occupancy
  always_comb begin
    wr_d = push_s ? wr_q + PW'(1) : wr_q;
    rd_d = pop_s  ? rd_q + PW'(1) : rd_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // pointer/count state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage array
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_q] <= {push_data_i, push_src_i};
  end
endmodule

// File: rtl/apb_xbar_rr.sv
// N x M crossbar with unicast/broadcast routing, round-robin arbitration per
// slave plus one global broadcast arbiter, and a FIFO on every slave port.
module apb_xbar_rr
  import apb_xbar_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEF,
  parameter int NUM_SLAVES  = NUM_SLAVES_DEF,
  parameter int NUM_BRDCST  = NUM_BRDCST_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic          pclk,
  input  logic          rstn,
  apb_xbar_rr_if.slave  bus,
  output logic [15:0]   err_cnt
);
  localparam int NM = NUM_MASTERS;
  localparam int NS = NUM_SLAVES;
  localparam int NB = NUM_BRDCST;
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int MW = (NM > 1) ? $clog2(NM) : 1;

  addr_class_e   cls_s    [NM];
  logic [NS-1:0] tmask_s  [NM];
  logic [NM-1:0] uni_req_s [NS];
  logic [NM-1:0] bc_req_s, ready_s, mrdy_s, fire_s;
  logic [NS-1:0] space_s, bc_tgt_s, push_s;
  rr_res_t       bc_res_s;
  rr_res_t       ug_res_s [NS];
  logic [MW-1:0] bc_idx_s;
  logic [MW-1:0] ug_idx_s   [NS];
  logic [MW-1:0] push_src_s [NS];
  logic [DW-1:0] push_data_s [NS];
  logic [MW-1:0] bc_ptr_q, bc_ptr_d;
  logic [MW-1:0] rr_ptr_q [NS];
  logic [MW-1:0] rr_ptr_d [NS];
  logic [15:0]   err_q, err_d;

  // address decode into class and target-slave mask
  always_comb begin
    int unsigned a_v;
    a_v = 0;
    for (int k = 0; k < NM; k++) begin
      a_v = 32'(bus.m_addr[k*AW +: AW]);
      if (a_v < NS) begin
        cls_s[k]   = UNICAST;
        tmask_s[k] = NS'(1) << a_v;
      end else if (a_v < NS + NB) begin
        cls_s[k]   = BRDCST;
        tmask_s[k] = bus.brdcst_sub[(a_v - NS)*NS +: NS];
      end else begin
        cls_s[k]   = INVALID;
        tmask_s[k] = '0;
      end
      bc_req_s[k] = bus.m_valid[k] && (cls_s[k] == BRDCST) && (tmask_s[k] != '0);
    end
  end

  // broadcast winner owns its targets; other broadcasters are kept out of every slave arbiter
  always_comb begin
    bc_res_s = rr_pick(RR_MAX'(bc_req_s), 32'(bc_ptr_q), NM);
    bc_idx_s = MW'(bc_res_s.idx);
    bc_tgt_s = bc_res_s.hit ? tmask_s[bc_idx_s] : '0;
    for (int s = 0; s < NS; s++) begin
      for (int k = 0; k < NM; k++) begin
        uni_req_s[s][k] = bus.m_valid[k] && (cls_s[k] == UNICAST) && tmask_s[k][s];
      end
      ug_res_s[s] = bc_tgt_s[s] ? '0 : rr_pick(RR_MAX'(uni_req_s[s]), 32'(rr_ptr_q[s]), NM);
      ug_idx_s[s] = MW'(ug_res_s[s].idx);
    end
  end

  // accept decision per master
  always_comb begin
    for (int k = 0; k < NM; k++) begin
      ready_s[k] = 1'b0;
      case (cls_s[k])
        UNICAST: begin
          for (int s = 0; s < NS; s++) begin
            ready_s[k] = ready_s[k] | (tmask_s[k][s] && ug_res_s[s].hit &&
                                       (ug_idx_s[s] == MW'(k)) && space_s[s]);
          end
        end
        BRDCST:  ready_s[k] = (tmask_s[k] == '0) ||
                              (bc_res_s.hit && (bc_idx_s == MW'(k)) &&
                               ((tmask_s[k] & ~space_s) == '0));
        INVALID: ready_s[k] = 1'b1;
        default: ready_s[k] = 1'b0;
      endcase
    end
    mrdy_s = ready_s & bus.m_valid & {NM{rstn}};
    fire_s = mrdy_s & bus.m_valid;
  end

  assign bus.m_ready = mrdy_s;

  // push selection per slave, pointer and error-counter next state
  always_comb begin
    logic [16:0] err_sum_v;
    for (int s = 0; s < NS; s++) begin
      if (bc_tgt_s[s] && fire_s[bc_idx_s]) begin
        push_s[s]     = 1'b1;
        push_src_s[s] = bc_idx_s;
      end else if (ug_res_s[s].hit && fire_s[ug_idx_s[s]]) begin
        push_s[s]     = 1'b1;
        push_src_s[s] = ug_idx_s[s];
      end else begin
        push_s[s]     = 1'b0;
        push_src_s[s] = '0;
      end
      push_data_s[s] = bus.m_data[push_src_s[s]*DW +: DW];
      if (ug_res_s[s].hit && fire_s[ug_idx_s[s]]) begin
        rr_ptr_d[s] = (ug_idx_s[s] == MW'(NM - 1)) ? '0 : ug_idx_s[s] + MW'(1);
      end else begin
        rr_ptr_d[s] = rr_ptr_q[s];
      end
    end
    if (bc_res_s.hit && fire_s[bc_idx_s]) begin
      bc_ptr_d = (bc_idx_s == MW'(NM - 1)) ? '0 : bc_idx_s + MW'(1);
    end else begin
      bc_ptr_d = bc_ptr_q;
    end
    err_sum_v = {1'b0, err_q};
    for (int k = 0; k < NM; k++) begin
      if (fire_s[k] && (cls_s[k] == INVALID)) err_sum_v = err_sum_v + 17'd1;
      else                                    err_sum_v = err_sum_v;
    end
    err_d = (err_sum_v > {1'b0, ERR_CNT_MAX}) ? ERR_CNT_MAX : err_sum_v[15:0];
  end

  // arbitration pointers and error counter
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      bc_ptr_q <= '0;
      err_q    <= '0;
      for (int s = 0; s < NS; s++) rr_ptr_q[s] <= '0;
    end else begin
      bc_ptr_q <= bc_ptr_d;
      err_q    <= err_d;
      for (int s = 0; s < NS; s++) rr_ptr_q[s] <= rr_ptr_d[s];
    end
  end

  assign err_cnt = err_q;

  for (genvar s = 0; s < NS; s++) begin : g_fifo
    logic full_s;
    apb_xbar_fifo #(.DW(DW), .SW(MW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (pclk),
      .rst_n       (rstn),
      .push_i      (push_s[s]),
      .push_data_i (push_data_s[s]),
      .push_src_i  (push_src_s[s]),
      .ready_i     (bus.s_ready[s]),
      .full_o      (full_s),
      .valid_o     (bus.s_valid[s]),
      .data_o      (bus.s_data[s*DW +: DW]),
      .src_o       (bus.s_src[s*MW +: MW])
    );
    assign space_s[s] = ~full_s;
  end
endmodule

// File: tb/tb_apb_xbar_rr.sv
// Bench for apb_xbar_rr: directed scenarios followed by randomized traffic
// checked against a queue-based reference model of the crossbar.
module tb_apb_xbar_rr;
  localparam int NM = 4, NS = 4, NB = 2, DW = 32, AW = 6, DEPTH = 4, MW = 2;

  logic        pclk = 1'b0;
  logic        rstn;
  logic [15:0] err_cnt;
  int          n_checks = 0;
  int          n_errors = 0;

  apb_xbar_rr_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .NUM_BRDCST(NB),
                   .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb_xbar_rr #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .NUM_BRDCST(NB),
                .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .pclk(pclk), .rstn(rstn), .bus(bus), .err_cnt(err_cnt));

  always #5 pclk = ~pclk;

  // reference model state
  logic [31:0]   mq_d [NS][$];
  int            mq_s [NS][$];
  int            m_bc_ptr;
  int            m_rr_ptr [NS];
  int            m_err;
  logic [NM-1:0] exp_ready;
  int            exp_win;
  int            exp_grant [NS];

  task automatic set_master(input int k, input logic v, input int a, input logic [31:0] d);
    bus.m_valid[k]         = v;
    bus.m_addr[k*AW +: AW] = AW'(a);
    bus.m_data[k*DW +: DW] = d;
  endtask

  function automatic logic [31:0] get_data(input int s);
    return bus.s_data[s*DW +: DW];
  endfunction

  function automatic int get_src(input int s);
    return int'(bus.s_src[s*MW +: MW]);
  endfunction

  function automatic int addr_of(input int k);
    return int'(bus.m_addr[k*AW +: AW]);
  endfunction

  function automatic logic [NS-1:0] targets_of(input int k);
    int a;
    a = addr_of(k);
    if (a < NS) return NS'(1) << a;
    if (a < NS + NB) return bus.brdcst_sub[(a - NS)*NS +: NS];
    return '0;
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    bus.m_valid = '0; bus.m_data = '0; bus.m_addr = '0;
    bus.s_ready = '0; bus.brdcst_sub = '0;
    repeat (2) @(posedge pclk);
    #1 rstn = 1'b1;
  endtask

  task automatic model_eval();
    int k, a;
    logic [NS-1:0] t;
    exp_ready = '0;
    exp_win = -1;
    for (int i = 0; i < NM; i++) begin
      k = (m_bc_ptr + i) % NM;
      a = addr_of(k);
      if (exp_win < 0 && bus.m_valid[k] && a >= NS && a < NS + NB && targets_of(k) != '0)
        exp_win = k;
    end
    for (int s = 0; s < NS; s++) begin
      exp_grant[s] = -1;
      if (!(exp_win >= 0 && targets_of(exp_win)[s])) begin
        for (int i = 0; i < NM; i++) begin
          k = (m_rr_ptr[s] + i) % NM;
          if (exp_grant[s] < 0 && bus.m_valid[k] && addr_of(k) == s) exp_grant[s] = k;
        end
      end
    end
    for (int j = 0; j < NM; j++) begin
      a = addr_of(j);
      t = targets_of(j);
      if (!bus.m_valid[j]) exp_ready[j] = 1'b0;
      else if (a >= NS + NB) exp_ready[j] = 1'b1;
      else if (a >= NS) begin
        if (t == '0) exp_ready[j] = 1'b1;
        else if (j == exp_win) begin
          exp_ready[j] = 1'b1;
          for (int s = 0; s < NS; s++)
            if (t[s] && mq_d[s].size() >= DEPTH) exp_ready[j] = 1'b0;
        end
      end else exp_ready[j] = (exp_grant[a] == j) && (mq_d[a].size() < DEPTH);
    end
  endtask

  task automatic model_commit();
    int a;
    logic [NS-1:0] t;
    for (int s = 0; s < NS; s++) begin
      if (mq_d[s].size() > 0 && bus.s_ready[s]) begin
        void'(mq_d[s].pop_front());
        void'(mq_s[s].pop_front());
      end
    end
    for (int k = 0; k < NM; k++) begin
      if (bus.m_valid[k] && exp_ready[k]) begin
        a = addr_of(k);
        t = targets_of(k);
        if (a >= NS + NB) m_err = (m_err < 65535) ? m_err + 1 : 65535;
        for (int s = 0; s < NS; s++) begin
          if (t[s]) begin
            mq_d[s].push_back(bus.m_data[k*DW +: DW]);
            mq_s[s].push_back(k);
          end
        end
      end
    end
    if (exp_win >= 0 && exp_ready[exp_win]) m_bc_ptr = (exp_win + 1) % NM;
    for (int s = 0; s < NS; s++)
      if (exp_grant[s] >= 0 && exp_ready[exp_grant[s]]) m_rr_ptr[s] = (exp_grant[s] + 1) % NM;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.s_ready = '0; bus.brdcst_sub = '0;
    for (int k = 0; k < NM; k++) set_master(k, 1'b1, k, 32'hA000_0000 + 32'(k));
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      n_checks++;
      if (bus.m_ready !== 4'h0 || bus.s_valid !== 4'h0 || err_cnt !== 16'h0 || bus.s_data !== '0) begin
        n_errors++;
        $display("FAIL reset_hold edge=%0d m_ready=%b s_valid=%b err_cnt=%0d (want 0)",
                 i, bus.m_ready, bus.s_valid, err_cnt);
      end
      @(posedge pclk);
    end
    #1 rstn = 1'b1;
    @(negedge pclk);
    n_checks++;
    if (bus.m_ready !== 4'hF) begin
      n_errors++; $display("FAIL reset_first_accept m_ready=%b want 1111", bus.m_ready);
    end
    @(posedge pclk); #1 bus.m_valid = '0;
    @(negedge pclk);
    n_checks++;
    if (bus.s_valid !== 4'hF || bus.s_src !== 8'hE4) begin
      n_errors++; $display("FAIL reset_first_out s_valid=%b s_src=%h want 1111/e4", bus.s_valid, bus.s_src);
    end
    for (int s = 0; s < NS; s++) begin
      n_checks++;
      if (get_data(s) !== 32'hA000_0000 + 32'(s)) begin
        n_errors++; $display("FAIL reset_first_data s=%0d got=%h want=%h", s, get_data(s), 32'hA000_0000 + 32'(s));
      end
    end
  endtask

  task automatic test_unicast();
    do_reset();
    set_master(0, 1'b1, 2, 32'hDEADBEEF);
    @(negedge pclk);
    n_checks++;
    if (bus.m_ready !== 4'b0001) begin
      n_errors++; $display("FAIL uni_ready got=%b want 0001", bus.m_ready);
    end
    @(posedge pclk); #1 bus.m_valid = '0;
    @(negedge pclk);
    n_checks++;
    if (bus.s_valid !== 4'b0100 || get_data(2) !== 32'hDEADBEEF || get_src(2) !== 0) begin
      n_errors++; $display("FAIL uni_out s_valid=%b data=%h src=%0d want 0100/deadbeef/0",
                           bus.s_valid, get_data(2), get_src(2));
    end
  endtask

  task automatic test_contention();
    logic [NM-1:0] exp_r;
    do_reset();
    for (int k = 0; k < NM; k++) set_master(k, 1'b1, 1, 32'hC000_0000 + 32'(k));
    bus.s_ready = 4'b0010;
    for (int c = 0; c < 9; c++) begin
      @(negedge pclk);
      exp_r = NM'(1) << (c % 4);
      n_checks++;
      if (bus.m_ready !== exp_r) begin
        n_errors++; $display("FAIL cont_grant cyc=%0d got=%b want=%b", c, bus.m_ready, exp_r);
      end
      if (c >= 1) begin
        n_checks++;
        if (bus.s_valid[1] !== 1'b1 || get_src(1) !== (c - 1) % 4 ||
            get_data(1) !== 32'hC000_0000 + 32'((c - 1) % 4)) begin
          n_errors++; $display("FAIL cont_src cyc=%0d valid=%b src=%0d want src=%0d",
                               c, bus.s_valid[1], get_src(1), (c - 1) % 4);
        end
      end
      @(posedge pclk);
    end
    #1;
  endtask

  task automatic test_backpressure();
    int sent, got;
    logic fire;
    do_reset();
    sent = 0;
    set_master(2, 1'b1, 3, 32'hB000_0000);
    for (int c = 0; c < 6; c++) begin
      @(negedge pclk);
      n_checks++;
      if (bus.m_ready[2] !== (c < 4)) begin
        n_errors++; $display("FAIL bp_fill cyc=%0d m_ready2=%b want=%0d", c, bus.m_ready[2], c < 4);
      end
      @(posedge pclk); #1;
      if (c < 4) begin
        sent++;
        set_master(2, 1'b1, 3, 32'hB000_0000 + 32'(sent));
      end
    end
    bus.s_ready[3] = 1'b1;
    @(negedge pclk);
    n_checks++;
    if (bus.m_ready[2] !== 1'b0 || get_data(3) !== 32'hB000_0000) begin
      n_errors++; $display("FAIL bp_full_pop m_ready2=%b head=%h want 0/b0000000", bus.m_ready[2], get_data(3));
    end
    @(posedge pclk); #1;
    got = 1;
    for (int c = 0; c < 20 && got < 6; c++) begin
      @(negedge pclk);
      if (bus.s_valid[3]) begin
        n_checks++;
        if (get_data(3) !== 32'hB000_0000 + 32'(got) || get_src(3) !== 2) begin
          n_errors++; $display("FAIL bp_order idx=%0d got=%h src=%0d want=%h", got, get_data(3),
                               get_src(3), 32'hB000_0000 + 32'(got));
        end
        got++;
      end
      fire = bus.m_valid[2] && bus.m_ready[2];
      @(posedge pclk); #1;
      if (fire) begin
        sent++;
        if (sent < 6) set_master(2, 1'b1, 3, 32'hB000_0000 + 32'(sent));
        else bus.m_valid[2] = 1'b0;
      end
    end
    n_checks++;
    if (got != 6 || sent != 6) begin
      n_errors++; $display("FAIL bp_complete got=%0d sent=%0d want 6/6", got, sent);
    end
  endtask

  task automatic test_broadcast();
    do_reset();
    bus.brdcst_sub = {4'b0110, 4'b1011};
    set_master(1, 1'b1, 4, 32'h12345678);
    set_master(3, 1'b1, 5, 32'hCAFE0003);
    @(negedge pclk);
    n_checks++;
    if (bus.m_ready !== 4'b0010) begin
      n_errors++; $display("FAIL bc_win got=%b want 0010", bus.m_ready);
    end
    @(posedge pclk); #1 bus.m_valid[1] = 1'b0;
    @(negedge pclk);
    n_checks++;
    if (bus.s_valid !== 4'b1011 || bus.m_ready !== 4'b1000) begin
      n_errors++; $display("FAIL bc_fanout s_valid=%b m_ready=%b want 1011/1000", bus.s_valid, bus.m_ready);
    end
    for (int s = 0; s < NS; s++) begin
      if (s != 2) begin
        n_checks++;
        if (get_data(s) !== 32'h12345678 || get_src(s) !== 1) begin
          n_errors++; $display("FAIL bc_data s=%0d got=%h src=%0d want 12345678/1", s, get_data(s), get_src(s));
        end
      end
    end
    @(posedge pclk); #1 bus.m_valid[3] = 1'b0;
    @(negedge pclk);
    n_checks++;
    if (bus.s_valid !== 4'b1111 || get_data(2) !== 32'hCAFE0003 || get_src(2) !== 3 ||
        get_data(1) !== 32'h12345678) begin
      n_errors++; $display("FAIL bc_second s_valid=%b s2=%h src=%0d s1=%h", bus.s_valid,
                           get_data(2), get_src(2), get_data(1));
    end
  endtask

  task automatic test_invalid_reset();
    do_reset();
    set_master(0, 1'b1, 6, 32'h0BAD0BAD);
    @(negedge pclk);
    n_checks++;
    if (bus.m_ready !== 4'b0001) begin
      n_errors++; $display("FAIL inv_ready got=%b want 0001", bus.m_ready);
    end
    @(posedge pclk); #1 bus.m_valid = '0;
    @(negedge pclk);
    n_checks++;
    if (bus.s_valid !== 4'h0 || err_cnt !== 16'd1) begin
      n_errors++; $display("FAIL inv_drop s_valid=%b err_cnt=%0d want 0/1", bus.s_valid, err_cnt);
    end
    @(posedge pclk); #1 set_master(0, 1'b1, 0, 32'h5000_0000);
    @(posedge pclk); #1 set_master(0, 1'b1, 0, 32'h5000_0001);
    @(posedge pclk); #1 bus.m_valid = '0;
    @(negedge pclk);
    n_checks++;
    if (bus.s_valid[0] !== 1'b1 || get_data(0) !== 32'h5000_0000) begin
      n_errors++; $display("FAIL inv_load s_valid0=%b data=%h want 1/50000000", bus.s_valid[0], get_data(0));
    end
    @(posedge pclk); #3 rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.s_valid !== 4'h0 || err_cnt !== 16'h0 || bus.s_data !== '0) begin
      n_errors++; $display("FAIL inv_async_rst s_valid=%b err_cnt=%0d want 0/0", bus.s_valid, err_cnt);
    end
    @(posedge pclk); #1 rstn = 1'b1;
    @(negedge pclk);
    n_checks++;
    if (bus.s_valid !== 4'h0 || bus.s_data !== '0) begin
      n_errors++; $display("FAIL inv_post_rst s_valid=%b want 0000", bus.s_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] ed;
    int          es;
    do_reset();
    for (int s = 0; s < NS; s++) begin
      mq_d[s].delete(); mq_s[s].delete(); m_rr_ptr[s] = 0;
    end
    m_bc_ptr = 0; m_err = 0; exp_ready = '0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NM; k++)
        if (!(bus.m_valid[k] && !exp_ready[k]))
          set_master(k, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
      bus.s_ready    = 4'($urandom);
      bus.brdcst_sub = 8'($urandom);
      @(negedge pclk);
      model_eval();
      n_checks++;
      if (bus.m_ready !== exp_ready) begin
        n_errors++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, bus.m_ready, exp_ready);
      end
      n_checks++;
      if (err_cnt !== 16'(m_err)) begin
        n_errors++; $display("FAIL rand_err cyc=%0d got=%0d want=%0d", c, err_cnt, m_err);
      end
      for (int s = 0; s < NS; s++) begin
        ed = (mq_d[s].size() > 0) ? mq_d[s][0] : 32'h0;
        es = (mq_s[s].size() > 0) ? mq_s[s][0] : 0;
        n_checks++;
        if (bus.s_valid[s] !== (mq_d[s].size() > 0) || get_data(s) !== ed || get_src(s) !== es) begin
          n_errors++; $display("FAIL rand_out cyc=%0d s=%0d valid=%b data=%h src=%0d want %0d/%h/%0d",
                               c, s, bus.s_valid[s], get_data(s), get_src(s), mq_d[s].size() > 0, ed, es);
        end
      end
      @(posedge pclk);
      model_commit();
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_contention();
    test_backpressure();
    test_broadcast();
    test_invalid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/apb_xbar_rr.md
Name: apb_xbar_rr

Overview:
- Parametrised, buffered successor to apb_interconnect: an N-master x M-slave crossbar with valid/ready backpressure on both sides.
- Supports multiple broadcast channels and round-robin arbitration per slave.
- Each slave port has an output FIFO.
- Sits between data producers (masters) and consumers (slaves) on the pclk domain.

Parameters:
- NUM_MASTERS, 4, number of master (input) ports
- NUM_SLAVES, 4, number of slave (output) ports
- NUM_BRDCST, 2, number of broadcast channels
- DATA_WIDTH, 32, payload width
- ADDR_WIDTH, 6, dest address width; must be >= clog2(NUM_SLAVES+NUM_BRDCST)
- FIFO_DEPTH, 4, entries per slave output FIFO (power of two, >=2)

Ports:
- pclk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- m_valid  in  NUM_MASTERS  per-master request valid
- m_ready  out  NUM_MASTERS  per-master accept
- m_data  in  NUM_MASTERS*DATA_WIDTH  flattened payloads; master k at [k*DW +: DW]
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  flattened destination addresses
- brdcst_sub  in  NUM_BRDCST*NUM_SLAVES  bit c*NUM_SLAVES+s = slave s subscribed to channel c
- s_valid  out  NUM_SLAVES  per-slave output valid
- s_ready  in  NUM_SLAVES  per-slave consume
- s_data  out  NUM_SLAVES*DATA_WIDTH  FIFO head payloads
- s_src  out  NUM_SLAVES*clog2(NUM_MASTERS)  originating master ID of the head entry
- err_cnt  out  16  saturating count of accepted invalid-address requests

Behaviour:
- Reset is asynchronous on rstn low. All outputs go to 0: m_ready, s_valid, s_data, s_src, err_cnt. FIFO pointers and counts clear. All round-robin pointers clear to 0.
- Address decode, combinational:
  - addr < NUM_SLAVES: unicast to slave addr.
  - NUM_SLAVES <= addr < NUM_SLAVES+NUM_BRDCST: broadcast on channel c = addr-NUM_SLAVES. Target set = brdcst_sub row c, sampled in the accept cycle.
  - Any other address: invalid.
- A transfer fires on the pclk rising edge when m_valid[k] & m_ready[k] are both high.
- Broadcast arbitration:
  - One global round-robin arbiter selects at most one broadcasting master per cycle, starting from bc_ptr.
  - The winner has priority at every target slave.
  - Non-winning broadcasters are masked from all slave arbiters that cycle, so broadcasts cannot deadlock.
  - When the winner fires, bc_ptr = winner+1 mod NUM_MASTERS.
- Slave arbitration:
  - Each slave s has a round-robin arbiter over unicast requesters addressed to s, starting from rr_ptr[s].
  - It grants only if no broadcast winner targets s.
  - When the granted master fires, rr_ptr[s] = granted+1 mod NUM_MASTERS. The pointer does not change otherwise.
- Space rule: slave s can accept when fifo_count[s] < FIFO_DEPTH. A pop in the same cycle does not create space (no pass-through).
- m_ready[k] = 1 when all of the following hold:
  - m_valid[k] is high.
  - For unicast: k holds the grant of its slave and that slave has space.
  - For broadcast: k is the broadcast winner and every subscribed slave has space.
  - For invalid: always (transfer is dropped; err_cnt += 1, saturating at 0xFFFF).
  - For a broadcast with zero subscribers: always (dropped, no error).
- Multi-target broadcast is atomic: it pushes into all targets in the same cycle, or into none.
- Latency: data accepted at edge N is visible on s_valid/s_data/s_src after edge N (FIFO registered, first-word-fall-through). Total latency 1 cycle when the FIFO was empty.
- FIFO behaviour:
  - Pop when s_valid & s_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Read/write pointers wrap mod FIFO_DEPTH.
  - s_data and s_src hold stable while s_valid=1 and s_ready=0.
- Ordering: per master/slave pair, FIFO order is preserved.
- m_ready is combinational from inputs and state. Masters must hold m_data and m_addr stable while m_valid=1 and m_ready=0.
- Reset asserted mid-operation discards all buffered entries immediately. No output glitches to stale data after release.

Decomposition:
- Package apb_xbar_pkg holds:
  - address-class enum {UNICAST, BRDCST, INVALID}
  - clog2-derived widths: MID_W = clog2(NUM_MASTERS), CNT_W = clog2(FIFO_DEPTH+1)
  - ERR_CNT_MAX = 16'hFFFF
- Sub-module apb_xbar_fifo (sync FIFO with data+src, count, FWFT), instantiated NUM_SLAVES times.
- Round-robin grant logic is a function in the package, reused for bc_ptr and rr_ptr.

Test Plan:
- Reset: hold rstn=0 across 3 edges with m_valid=4'hF. Required: m_ready=0, s_valid=0, err_cnt=0 throughout. After release, first accept occurs on the first edge.
- Unicast: M0 sends addr=2, data=32'hDEADBEEF. Required: m_ready[0]=1 in the same cycle. Next cycle s_valid[2]=1, s_data=DEADBEEF, s_src=0. All other s_valid stay 0.
- Contention: M0-M3 continuously send to slave 1 with s_ready[1]=1. Required: s_src sequence 0,1,2,3,0,1. Each master is granted once per 4 cycles.
- Backpressure: M2 streams 6 words to slave 3 with s_ready[3]=0, FIFO_DEPTH=4. Required: 4 accepted, then m_ready[2]=0. After s_ready[3]=1, the remaining 2 are accepted in order with no loss.
- Broadcast: brdcst_sub channel 0 = 4'b1011; M1 sends addr=4, data=32'h12345678 while M3 sends addr=5 in the same cycle. Required: M1 wins (bc_ptr=0); S0, S1 and S3 receive 12345678 with s_src=1; S2 receives nothing. M3 fires on a later cycle.
- Invalid plus reset mid-flight: M0 sends addr=6. Required: ready=1, no s_valid, err_cnt=1. Then load 2 entries into S0 and pulse rstn low. Required: s_valid[0]=0 immediately and err_cnt=0.
